pfumx_nch_reg: RTL and testbench
================================

// Module: pfumx_nch_reg
// PURPOSE
//  Parametrised successor to the PFU 2:1 slice mux. NCH-channel, WIDTH-bit mux with a
//  registered select, valid/ready handshake and a 2-entry output skid buffer.
//  Modes: host-selected (fixed) or round-robin among valid channels.
//  Sits between LUT-level datapaths and registered consumers in ECP2-class designs.
// PARAMETERS
//  WIDTH  8  data bits per channel (>=1)
//  NCH    4  channel count (2..16)
//  MODE   0  0 = fixed select via C/SLD; 1 = round-robin arbitration
//  SELW   -  localparam = max(1, clog2(NCH)); not overridable
// PORTS
//  CK    in   1          clock; all state updates on rising edge
//  CD    in   1          synchronous active-high reset
//  D     in   NCH*WIDTH  channel data; channel i at D[i*WIDTH +: WIDTH]
//  DV    in   NCH        per-channel valid
//  DRDY  out  NCH        per-channel ready; one-hot or zero
//  C     in   SELW       requested select (MODE 0 only)
//  SLD   in   1          load C into select register (MODE 0 only)
//  Z     out  WIDTH      head of output buffer
//  ZV    out  1          Z valid
//  ZRDY  in   1          downstream ready; pop when ZV && ZRDY
//  GNT   out  SELW       source channel of the entry at Z
//  ERR   out  1          sticky: SLD with C >= NCH seen
// BEHAVIOUR
//  Reset (CD=1 at edge):
//   - Buffer emptied; ZV=0, Z=0, GNT=0, ERR=0, SELR=0.
//   - Round-robin pointer = NCH-1, so channel 0 has priority first.
//   - Overrides any in-flight transfer; DRDY=0 during the reset cycle.
//  Grant g:
//   - MODE 0: g = SELR.
//   - MODE 1: first i with DV[i]=1, searching from ptr+1 upward mod NCH; none -> no grant.
//  Ready and accept:
//   - DRDY[g] = !full (count<2); all other DRDY bits 0. DRDY never depends on ZRDY.
//   - Accept when DV[g] && DRDY[g]: push {D[g], g}.
//   - MODE 1: ptr <= g only on accept.
//  SELR update (MODE 0):
//   - SLD && C<NCH: SELR <= C at the edge; same-cycle accept still uses old SELR.
//   - SLD && C>=NCH: SELR unchanged; ERR <= 1.
//   - SLD and C ignored in MODE 1.
//  Latency: accept at edge n -> ZV=1 with that data after edge n (1 cycle) when empty.
//  Buffer:
//   - count 0..2, FIFO order.
//   - Push+pop at count 1: count stays 1, Z advances to new entry.
//   - Push at count 2 is impossible (DRDY=0).
//   - Pop at count 0 is ignored.
//   - Z and GNT stable while ZV && !ZRDY. Z holds last popped value when empty.
//   - Throughput 1 word/cycle sustained when ZRDY=1.
// STRUCTURE
//  Shared package/include: MODE_FIXED=0, MODE_RR=1; clog2 constant function.
//  Sub-module pfumx_skid: 2-entry FIFO of width WIDTH+SELW with push/pop/count.
//  Top: select register, RR pointer, priority search, DRDY decode, ERR flag.
// TESTING
//  1 MODE0, WIDTH=8, NCH=4: SLD C=2, DV=4'b0100, D[2]=8'hA5, ZRDY=1
//    -> ZV next cycle, Z=A5, GNT=2.
//  2 Backpressure, ZRDY=0, 3 words 11,22,33 on ch0 -> 11,22 accepted, DRDY[0]=0 after 2;
//    ZRDY=1 -> Z=11 then 22 then 33, in order.
//  3 MODE1, DV=4'b1111 held, ZRDY=1 -> GNT sequence 0,1,2,3,0; DV=4'b1010 -> 1,3,1,3.
//  4 MODE0, SLD C=5 -> ERR=1 and sticky, SELR unchanged; same-cycle SLD C=1 with accept
//    on ch0 -> word tagged GNT=0.
//  5 CD asserted with count=2, ZV=1 -> next cycle ZV=0, ERR=0, DRDY[0]=1 (MODE0);
//    MODE1 first grant is ch0.
//  6 NCH=2, WIDTH=1: equivalence against 2:1 mux + flop reference under random DV/ZRDY.

Source files
------------

// File: rtl/pfumx_nch_reg_pkg.sv
// Shared constants and width helpers for the NCH-channel registered mux.
package pfumx_nch_reg_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Ceiling log2 for n >= 1; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Width of a channel index. It is never narrower than one bit.
  function automatic int sel_width(input int nch);
    return (clog2(nch) > 1) ? clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/pfumx_nch_reg_if.sv
// Bus bundle for pfumx_nch_reg: channel inputs, select control and output stream.
interface pfumx_nch_reg_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  import pfumx_nch_reg_pkg::*;

  localparam int SELW = sel_width(NCH);

  logic [NCH*WIDTH-1:0] D;
  logic [NCH-1:0]       DV;
  logic [NCH-1:0]       DRDY;
  logic [SELW-1:0]      C;
  logic                 SLD;
  logic [WIDTH-1:0]     Z;
  logic                 ZV;
  logic                 ZRDY;
  logic [SELW-1:0]      GNT;
  logic                 ERR;

  modport master (
    output D, DV, C, SLD, ZRDY,
    input  DRDY, Z, ZV, GNT, ERR
  );

  modport slave (
    input  D, DV, C, SLD, ZRDY,
    output DRDY, Z, ZV, GNT, ERR
  );

endinterface

// File: rtl/pfumx_nch_reg_skid.sv
// Two-entry FIFO that sits at the mux output. Entry 0 is always the head,
// and it keeps the last popped word once the FIFO has drained.
module pfumx_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] entry0_q, entry0_d;
  logic [W-1:0] entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // Next-state of the two entries and the fill count, with pushes and pops qualified by occupancy
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && (count_q != 2'd2);
    case (count_q)
      2'd0: begin
        if (do_push) begin
          entry0_d = push_data;
          count_d  = 2'd1;
        end
      end
      2'd1: begin
        if (do_push && do_pop) begin
          entry0_d = push_data;
        end else if (do_push) begin
          entry1_d = push_data;
          count_d  = 2'd2;
        end else if (do_pop) begin
          count_d  = 2'd0;
        end
      end
      default: begin
        if (do_pop) begin
          entry0_d = entry1_q;
          count_d  = 2'd1;
        end
      end
    endcase
  end

  // Storage registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign head  = entry0_q;
  assign count = count_q;

endmodule

// File: rtl/pfumx_nch_reg.sv
// NCH-channel WIDTH-bit registered mux. It selects a channel by host select or by
// round-robin, uses a valid/ready handshake, and feeds a 2-entry output skid buffer
// that tags each word with its source channel.
module pfumx_nch_reg
  import pfumx_nch_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int MODE  = MODE_FIXED
) (
  input logic              CK,
  input logic              CD,
  pfumx_nch_reg_if.slave   bus
);

  localparam int SELW = sel_width(NCH);
  localparam int EW   = WIDTH + SELW;

  logic [SELW-1:0]  selr_q, selr_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             err_q, err_d;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  cand;
  logic             grant_vld;
  logic             accept;
  logic             full;
  logic [WIDTH-1:0] sel_data;
  logic [EW-1:0]    head;
  logic [1:0]       count;

  // Choose the granted channel: the select register, or the first valid channel after the pointer
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (MODE == MODE_RR) begin
      for (int k = 1; k <= NCH; k++) begin
        cand = SELW'((int'(ptr_q) + k) % NCH);
        if (!grant_vld && bus.DV[cand]) begin
          grant     = cand;
          grant_vld = 1'b1;
        end
      end
    end else begin
      grant     = selr_q;
      grant_vld = 1'b1;
    end
  end

  // Drive ready to the granted channel only. It is independent of downstream ready and held low during reset
  always_comb begin
    bus.DRDY = '0;
    accept   = 1'b0;
    if (!CD && grant_vld && !full) begin
      bus.DRDY[grant] = 1'b1;
      accept          = bus.DV[grant];
    end
  end

  assign sel_data = bus.D[int'(grant)*WIDTH +: WIDTH];
  assign full     = (count == 2'd2);

  // Update the select register, the round-robin pointer and the sticky bad-select flag
  always_comb begin
    selr_d = selr_q;
    ptr_d  = ptr_q;
    err_d  = err_q;
    if (MODE == MODE_RR) begin
      if (accept) begin
        ptr_d = grant;
      end
    end else if (bus.SLD) begin
      if (int'(bus.C) < NCH) begin
        selr_d = bus.C;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Control registers. The pointer resets to the last channel, so channel 0 wins first
  always_ff @(posedge CK) begin
    if (CD) begin
      selr_q <= '0;
      ptr_q  <= SELW'(NCH - 1);
      err_q  <= 1'b0;
    end else begin
      selr_q <= selr_d;
      ptr_q  <= ptr_d;
      err_q  <= err_d;
    end
  end

  pfumx_skid #(.W(EW)) u_skid (
    .clk       (CK),
    .rst       (CD),
    .push      (accept),
    .push_data ({sel_data, grant}),
    .pop       (bus.ZV && bus.ZRDY),
    .head      (head),
    .count     (count)
  );

  assign bus.Z   = head[EW-1:SELW];
  assign bus.GNT = head[SELW-1:0];
  assign bus.ZV  = (count != 2'd0);
  assign bus.ERR = err_q;

endmodule

// File: tb/tb_pfumx_nch_reg.sv
// Self-checking bench for pfumx_nch_reg. It covers four configurations, each
// compared cycle by cycle against a queue-based reference model.
module tb_pfumx_nch_reg;
  import pfumx_nch_reg_pkg::*;

  logic CK;
  logic cd;

  pfumx_nch_reg_if #(.WIDTH(8), .NCH(4)) if0 ();
  pfumx_nch_reg_if #(.WIDTH(8), .NCH(4)) if1 ();
  pfumx_nch_reg_if #(.WIDTH(1), .NCH(2)) if2 ();
  pfumx_nch_reg_if #(.WIDTH(8), .NCH(3)) if3 ();

  pfumx_nch_reg #(.WIDTH(8), .NCH(4), .MODE(MODE_FIXED)) u0 (.CK(CK), .CD(cd), .bus(if0.slave));
  pfumx_nch_reg #(.WIDTH(8), .NCH(4), .MODE(MODE_RR))    u1 (.CK(CK), .CD(cd), .bus(if1.slave));
  pfumx_nch_reg #(.WIDTH(1), .NCH(2), .MODE(MODE_FIXED)) u2 (.CK(CK), .CD(cd), .bus(if2.slave));
  pfumx_nch_reg #(.WIDTH(8), .NCH(3), .MODE(MODE_FIXED)) u3 (.CK(CK), .CD(cd), .bus(if3.slave));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int tests_run = 0;
  int tests_failed = 0;

  // generic per-cycle stimulus
  logic [7:0]  in_d [16];
  logic [15:0] in_dv;
  int          in_c;
  bit          in_sld, in_zrdy, in_cd;

  // observed outputs
  int obs_z, obs_zv, obs_gnt, obs_err, obs_drdy;

  // reference model state
  int m_nch, m_mode, m_mask;
  int mq_d[$];
  int mq_g[$];
  int m_sel, m_ptr, m_err, m_lastz, m_lastg;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic clearInputs();
    for (int i = 0; i < 16; i++) in_d[i] = 8'h00;
    in_dv = '0; in_c = 0; in_sld = 0; in_zrdy = 0; in_cd = 0;
  endtask

  task automatic driveBus(input int inst);
    case (inst)
      0: begin
        for (int i = 0; i < 4; i++) if0.D[i*8 +: 8] = in_d[i];
        if0.DV = in_dv[3:0]; if0.C = 2'(in_c); if0.SLD = in_sld; if0.ZRDY = in_zrdy;
      end
      1: begin
        for (int i = 0; i < 4; i++) if1.D[i*8 +: 8] = in_d[i];
        if1.DV = in_dv[3:0]; if1.C = 2'(in_c); if1.SLD = in_sld; if1.ZRDY = in_zrdy;
      end
      2: begin
        for (int i = 0; i < 2; i++) if2.D[i] = in_d[i][0];
        if2.DV = in_dv[1:0]; if2.C = 1'(in_c); if2.SLD = in_sld; if2.ZRDY = in_zrdy;
      end
      default: begin
        for (int i = 0; i < 3; i++) if3.D[i*8 +: 8] = in_d[i];
        if3.DV = in_dv[2:0]; if3.C = 2'(in_c); if3.SLD = in_sld; if3.ZRDY = in_zrdy;
      end
    endcase
  endtask

  task automatic sampleBus(input int inst);
    case (inst)
      0: begin obs_z = int'(if0.Z); obs_zv = int'(if0.ZV); obs_gnt = int'(if0.GNT); obs_err = int'(if0.ERR); obs_drdy = int'(if0.DRDY); end
      1: begin obs_z = int'(if1.Z); obs_zv = int'(if1.ZV); obs_gnt = int'(if1.GNT); obs_err = int'(if1.ERR); obs_drdy = int'(if1.DRDY); end
      2: begin obs_z = int'(if2.Z); obs_zv = int'(if2.ZV); obs_gnt = int'(if2.GNT); obs_err = int'(if2.ERR); obs_drdy = int'(if2.DRDY); end
      default: begin obs_z = int'(if3.Z); obs_zv = int'(if3.ZV); obs_gnt = int'(if3.GNT); obs_err = int'(if3.ERR); obs_drdy = int'(if3.DRDY); end
    endcase
  endtask

  task automatic modelReset();
    mq_d.delete(); mq_g.delete();
    m_sel = 0; m_ptr = m_nch - 1; m_err = 0; m_lastz = 0; m_lastg = 0;
  endtask

  // Hold reset for a couple of cycles with idle inputs, then start the model fresh
  task automatic resetPhase(input int inst, input int nch, input int mode, input int w);
    m_nch = nch; m_mode = mode; m_mask = (1 << w) - 1;
    clearInputs();
    @(negedge CK); cd = 1'b1; driveBus(inst);
    @(negedge CK); @(negedge CK); cd = 1'b0;
    modelReset();
  endtask

  // One clock of stimulus: drive at the falling edge, check, then advance the model at the rising edge
  task automatic applyStimulus(input int inst);
    bit vld;
    int g, exp_drdy, cc;
    @(negedge CK);
    cd = in_cd;
    driveBus(inst);
    #1;
    vld = 0; g = 0;
    if (m_mode == MODE_FIXED) begin
      vld = 1; g = m_sel;
    end else begin
      for (int k = 1; k <= m_nch; k++) begin
        cc = (m_ptr + k) % m_nch;
        if (!vld && in_dv[cc]) begin vld = 1; g = cc; end
      end
    end
    exp_drdy = (!in_cd && vld && mq_d.size() < 2) ? (1 << g) : 0;
    sampleBus(inst);
    checkOutput("ZV",   obs_zv,   (mq_d.size() > 0) ? 1 : 0);
    checkOutput("Z",    obs_z,    (mq_d.size() > 0) ? mq_d[0] : m_lastz);
    checkOutput("GNT",  obs_gnt,  (mq_g.size() > 0) ? mq_g[0] : m_lastg);
    checkOutput("ERR",  obs_err,  m_err);
    checkOutput("DRDY", obs_drdy, exp_drdy);
    @(posedge CK);
    if (in_cd) begin
      modelReset();
    end else begin
      if (mq_d.size() > 0 && in_zrdy) begin
        m_lastz = mq_d.pop_front();
        m_lastg = mq_g.pop_front();
      end
      if (exp_drdy != 0 && in_dv[g]) begin
        mq_d.push_back(int'(in_d[g]) & m_mask);
        mq_g.push_back(g);
        if (m_mode == MODE_RR) m_ptr = g;
      end
      if (m_mode == MODE_FIXED && in_sld) begin
        if (in_c < m_nch) m_sel = in_c;
        else m_err = 1;
      end
    end
  endtask

  task automatic randomRun(input int inst, input int n, input int cmax);
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < 16; i++) in_d[i] = 8'($urandom);
      in_dv   = 16'($urandom);
      in_sld  = ($urandom_range(0, 7) == 0);
      in_c    = $urandom_range(0, cmax);
      in_zrdy = ($urandom_range(0, 3) != 0);
      in_cd   = ($urandom_range(0, 63) == 0);
      applyStimulus(inst);
    end
    clearInputs();
  endtask

  int gnt_seq [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};

  initial begin
    clearInputs();
    cd = 1'b1;
    for (int k = 0; k < 4; k++) driveBus(k);
    repeat (3) @(posedge CK);

    // ---- fixed select, 4 x 8 ----
    resetPhase(0, 4, MODE_FIXED, 8);
    in_sld = 1; in_c = 2; applyStimulus(0);
    in_sld = 0; in_dv = 16'h0004; in_d[2] = 8'hA5; in_zrdy = 1; applyStimulus(0);
    in_dv = 0; applyStimulus(0);
    checkOutput("t1_z", obs_z, 8'hA5);
    checkOutput("t1_gnt", obs_gnt, 2);
    in_sld = 1; in_c = 0; applyStimulus(0);
    in_sld = 0; in_zrdy = 0; in_dv = 16'h0001;
    in_d[0] = 8'h11; applyStimulus(0);
    in_d[0] = 8'h22; applyStimulus(0);
    in_d[0] = 8'h33; applyStimulus(0);
    in_d[0] = 8'h33; applyStimulus(0);
    checkOutput("t2_full_drdy", obs_drdy, 0);
    in_zrdy = 1; applyStimulus(0);
    checkOutput("t2_first", obs_z, 8'h11);
    applyStimulus(0);
    checkOutput("t2_second", obs_z, 8'h22);
    in_dv = 0; applyStimulus(0);
    checkOutput("t2_third", obs_z, 8'h33);
    in_zrdy = 0; in_dv = 16'h0001; in_d[0] = 8'h44; applyStimulus(0);
    in_d[0] = 8'h55; applyStimulus(0);
    in_cd = 1; applyStimulus(0);
    checkOutput("t5_zv_before", obs_zv, 1);
    in_cd = 0; applyStimulus(0);
    checkOutput("t5_zv", obs_zv, 0);
    checkOutput("t5_drdy", obs_drdy, 1);
    randomRun(0, 300, 3);

    // ---- round-robin, 4 x 8 ----
    resetPhase(1, 4, MODE_RR, 8);
    in_dv = 16'h000F; in_zrdy = 1;
    for (int s = 1; s <= 10; s++) begin
      if (s == 7) in_dv = 16'h000A;
      for (int i = 0; i < 4; i++) in_d[i] = 8'(s * 16 + i);
      applyStimulus(1);
      if (s >= 2) checkOutput("t3_gnt_seq", obs_gnt, gnt_seq[s-2]);
    end
    in_zrdy = 0; in_dv = 16'h0002; applyStimulus(1); applyStimulus(1);
    in_cd = 1; applyStimulus(1);
    in_cd = 0; in_dv = 16'h000F; applyStimulus(1);
    checkOutput("t5_rr_drdy", obs_drdy, 1);
    randomRun(1, 300, 3);

    // ---- fixed select, 2 x 1 (plain 2:1 mux plus flop) ----
    resetPhase(2, 2, MODE_FIXED, 1);
    randomRun(2, 400, 1);

    // ---- fixed select, 3 x 8 (out-of-range select reachable) ----
    resetPhase(3, 3, MODE_FIXED, 8);
    in_sld = 1; in_c = 3; applyStimulus(3);
    in_sld = 0; in_dv = 16'h0001; in_zrdy = 1; in_d[0] = 8'h3C; applyStimulus(3);
    checkOutput("t4_err", obs_err, 1);
    checkOutput("t4_sel_kept", obs_drdy, 1);
    in_sld = 1; in_c = 1; in_d[0] = 8'h5A; applyStimulus(3);
    in_sld = 0; in_dv = 0; applyStimulus(3);
    checkOutput("t4_gnt", obs_gnt, 0);
    checkOutput("t4_z", obs_z, 8'h5A);
    checkOutput("t4_err_sticky", obs_err, 1);
    checkOutput("t4_new_sel", obs_drdy, 2);
    randomRun(3, 200, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
